// File: rtl/wb_pkg.sv
// Shared definitions for the multi-issue writeback stage.
// Covers lane field layout, output bus widths, stall encodings and the trace entry.
// No logic here apart from a field-unpacking helper.
package wb_pkg;

    // One MEM->WB lane, MSB first: valid, pc, rf_we, rf_waddr, rf_wdata,
    // hi_we, hi_wdata, lo_we, lo_wdata.
    localparam int LANE_W        = 137;
    localparam int LANE_VALID    = 136;
    localparam int LANE_PC       = 104;
    localparam int LANE_RF_WE    = 103;
    localparam int LANE_RF_WADDR = 98;
    localparam int LANE_RF_WDATA = 66;
    localparam int LANE_HI_WE    = 65;
    localparam int LANE_HI_WDATA = 33;
    localparam int LANE_LO_WE    = 32;
    localparam int LANE_LO_WDATA = 0;

    localparam int RF_LANE_W = 38;
    localparam int HILO_W    = 66;
    localparam int TE_W      = 70;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        hi_we;
        logic [31:0] hi_wdata;
        logic        lo_we;
        logic [31:0] lo_wdata;
    } lane_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } trace_entry_t;

    function automatic lane_t lane_unpack(input logic [LANE_W-1:0] v);
        lane_t l;
        l.valid    = v[LANE_VALID];
        l.pc       = v[LANE_PC +: 32];
        l.rf_we    = v[LANE_RF_WE];
        l.rf_waddr = v[LANE_RF_WADDR +: 5];
        l.rf_wdata = v[LANE_RF_WDATA +: 32];
        l.hi_we    = v[LANE_HI_WE];
        l.hi_wdata = v[LANE_HI_WDATA +: 32];
        l.lo_we    = v[LANE_LO_WE];
        l.lo_wdata = v[LANE_LO_WDATA +: 32];
        return l;
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Trace FIFO: up to LANES pushes per cycle (packed in lane order), one pop per cycle.
// Latency: head entry appears on pop_dat_o the cycle after it is popped; zero otherwise.
// Backpressure: stallreq_o when free slots < LANES; excess pushes dropped, sticky overflow_o.
import wb_pkg::*;

module wb_trace_fifo #(
    parameter int LANES = 2,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      push_vld_i,
    input  logic [LANES*TE_W-1:0] push_dat_i,
    output logic [TE_W-1:0]       pop_dat_o,
    output logic                  stallreq_o,
    output logic                  overflow_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [TE_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, ptr_c;
    logic [CW-1:0]   count_q, space_c, acc_c;
    logic            overflow_q, pop_c, drop_c;
    logic [TE_W-1:0] out_q;
    logic [LANES-1:0] wr_en_c;
    logic [PW-1:0]   slot_c [LANES];

    // Slot allocation: a slot freed by this cycle's pop is reusable, oldest lanes win.
    always_comb begin
        pop_c   = (count_q != '0);
        space_c = DEPTH_C - count_q + CW'(pop_c);
        ptr_c   = wptr_q;
        acc_c   = '0;
        drop_c  = 1'b0;
        wr_en_c = '0;
        for (int l = 0; l < LANES; l++) begin
            slot_c[l] = ptr_c;
            if (push_vld_i[l]) begin
                if (acc_c < space_c) begin
                    wr_en_c[l] = 1'b1;
                    acc_c      = acc_c + CW'(1);
                    ptr_c      = (ptr_c == PTR_LAST) ? '0 : ptr_c + PW'(1);
                end else begin
                    drop_c = 1'b1;
                end
            end
        end
        wptr_d = ptr_c;
    end

    // Entry storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (wr_en_c[l]) begin
                mem_q[slot_c[l]] <= push_dat_i[TE_W*l +: TE_W];
            end
        end
    end

    // Pointers, occupancy, sticky overflow and the registered head output.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            out_q      <= '0;
        end else begin
            wptr_q     <= wptr_d;
            count_q    <= count_q + acc_c - CW'(pop_c);
            overflow_q <= overflow_q | drop_c;
            if (pop_c) begin
                out_q  <= mem_q[rptr_q];
                rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
            end else begin
                out_q  <= '0;
            end
        end
    end

    assign pop_dat_o  = out_q;
    assign stallreq_o = (DEPTH_C - count_q) < CW'(LANES);
    assign overflow_o = overflow_q;

endmodule

// File: rtl/wb_stage_multi.sv
// Multi-issue writeback: registers LANES MEM results, drives RF/HILO writes and a serial trace.
// Latency: RF/HILO combinational from the stage register; trace 2+ cycles after load.
// Backpressure: obeys the stall bus; raises stallreq_wb when the trace FIFO lacks LANES free slots.
import wb_pkg::*;

module wb_stage_multi #(
    parameter int LANES   = 2,
    parameter int DEPTH   = 8,
    parameter int STAGE   = 4,
    parameter int STALL_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [STALL_W-1:0]         stall,
    input  logic [LANES*LANE_W-1:0]    mem_to_wb_bus,
    output logic [LANES*RF_LANE_W-1:0] wb_to_rf_bus,
    output logic [HILO_W-1:0]          wb_to_hilo_bus,
    output logic                       stallreq_wb,
    output logic                       overflow_err,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    logic [LANES*LANE_W-1:0] stage_q, stage_d;
    logic                    fresh_q, fresh_d;
    lane_t                   lane [LANES];
    logic [LANES-1:0]        eff_we, kill_we, push_vld;
    logic [LANES*TE_W-1:0]   push_dat;
    logic [TE_W-1:0]         pop_dat;
    trace_entry_t            head;
    logic                    stall_unused;

    assign stall_unused = ^stall;

    // Stage register next state: flush, then bubble, then load, else hold.
    always_comb begin
        stage_d = stage_q;
        fresh_d = 1'b0;
        if (flush) begin
            stage_d = '0;
        end else if (stall[STAGE] == STOP && stall[STAGE+1] == NOSTOP) begin
            stage_d = '0;
        end else if (stall[STAGE] == NOSTOP) begin
            stage_d = mem_to_wb_bus;
            fresh_d = 1'b1;
        end
    end

    // Stage register; fresh marks the one cycle a new bundle may enter the trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            fresh_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            fresh_q <= fresh_d;
        end
    end

    // Split the registered bundle into lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane[l] = lane_unpack(stage_q[LANE_W*l +: LANE_W]);
        end
    end

    // Regfile writes; an older lane yields to a younger lane writing the same nonzero register.
    always_comb begin
        eff_we       = '0;
        kill_we      = '0;
        wb_to_rf_bus = '0;
        for (int i = 0; i < LANES; i++) begin
            eff_we[i] = lane[i].valid & lane[i].rf_we;
        end
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (eff_we[i] && eff_we[j] && lane[i].rf_waddr != 5'd0 &&
                    lane[j].rf_waddr == lane[i].rf_waddr) begin
                    kill_we[i] = 1'b1;
                end
            end
            wb_to_rf_bus[RF_LANE_W*i +: RF_LANE_W] =
                {eff_we[i] & ~kill_we[i], lane[i].rf_waddr, lane[i].rf_wdata};
        end
    end

    // HI/LO merge: any valid lane enables, the youngest valid writer supplies data.
    always_comb begin
        wb_to_hilo_bus = '0;
        for (int l = 0; l < LANES; l++) begin
            if (lane[l].valid && lane[l].hi_we) begin
                wb_to_hilo_bus[65]    = 1'b1;
                wb_to_hilo_bus[64:33] = lane[l].hi_wdata;
            end
            if (lane[l].valid && lane[l].lo_we) begin
                wb_to_hilo_bus[32]   = 1'b1;
                wb_to_hilo_bus[31:0] = lane[l].lo_wdata;
            end
        end
    end

    // Trace push candidates: every valid lane of a freshly loaded bundle, rf_we as loaded.
    always_comb begin
        push_vld = '0;
        push_dat = '0;
        for (int l = 0; l < LANES; l++) begin
            push_vld[l] = fresh_q & lane[l].valid;
            push_dat[TE_W*l +: TE_W] =
                {lane[l].pc, lane[l].rf_we, lane[l].rf_waddr, lane[l].rf_wdata};
        end
    end

    wb_trace_fifo #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (push_vld),
        .push_dat_i (push_dat),
        .pop_dat_o  (pop_dat),
        .stallreq_o (stallreq_wb),
        .overflow_o (overflow_err)
    );

    assign head              = trace_entry_t'(pop_dat);
    assign debug_wb_pc       = head.pc;
    assign debug_wb_rf_wen   = {4{head.rf_we}};
    assign debug_wb_rf_wnum  = head.waddr;
    assign debug_wb_rf_wdata = head.wdata;

endmodule
